// File: rtl/comparator_signed_serial_rx_if.sv
// Stream bundle for the digit-serial comparator: digit-pair input channel and verdict output channel.
interface comparator_signed_serial_rx_if #(
  parameter int DIGIT = 4,
  parameter int IDX_W = 4
) ();
  logic             in_valid;
  logic             in_ready;
  logic [DIGIT-1:0] in_a;
  logic [DIGIT-1:0] in_b;
  logic             out_valid;
  logic             out_ready;
  logic             out_lt;
  logic             out_eq;
  logic             out_gt;
  logic [IDX_W-1:0] out_idx;

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_lt, out_eq, out_gt, out_idx
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_lt, out_eq, out_gt, out_idx
  );
endinterface

// File: rtl/comparator_signed_serial_rx.sv
// Digit-serial lt/eq/gt comparator: operands arrive MSB-first, DIGIT bits per beat; the first
// differing digit decides the verdict and later digits are drained without effect.
module comparator_signed_serial_rx #(
  parameter int WIDTH  = 32,
  parameter int DIGIT  = 4,
  parameter bit SIGNED = 1'b1
) (
  input logic clk,
  input logic rst,
  comparator_signed_serial_rx_if.slave bus
);
  localparam int N     = (DIGIT >= 1) ? WIDTH / DIGIT : 1;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam int IDX_W = $clog2(N) + 1;

  if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
    $fatal(1, "comparator_signed_serial_rx: WIDTH must be a positive multiple of DIGIT");
  end

  typedef enum logic {ACCEPT, RESULT} state_t;

  state_t             r_state, w_state_next;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_decided;
  logic               r_acc_lt;
  logic [IDX_W-1:0]   r_acc_idx;
  logic               r_out_lt, r_out_eq, r_out_gt;
  logic [IDX_W-1:0]   r_out_idx;

  logic               w_in_ready, w_out_valid;
  logic               w_accept, w_release, w_last;
  logic [DIGIT-1:0]   w_a_dig, w_b_dig;
  logic               w_diff, w_dig_lt;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= ACCEPT;
    else     r_state <= w_state_next;
  end

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_in_ready   = 1'b0;
    w_out_valid  = 1'b0;
    case (r_state)
      ACCEPT: begin
        w_in_ready = 1'b1;
        if (bus.in_valid && w_last) w_state_next = RESULT;
      end
      RESULT: begin
        w_out_valid = 1'b1;
        if (bus.out_ready) w_state_next = ACCEPT;
      end
      default: w_state_next = ACCEPT;
    endcase
  end

  assign w_accept  = bus.in_valid & w_in_ready;
  assign w_release = w_out_valid & bus.out_ready;
  assign w_last    = (r_cnt == CNT_W'(N - 1));

  // Offset-binary trick: flipping the sign bit of the leading digit turns a signed compare unsigned.
  always_comb begin
    w_a_dig = bus.in_a;
    w_b_dig = bus.in_b;
    if (SIGNED && (r_cnt == '0)) begin
      w_a_dig[DIGIT-1] = ~bus.in_a[DIGIT-1];
      w_b_dig[DIGIT-1] = ~bus.in_b[DIGIT-1];
    end
  end

  assign w_diff   = (w_a_dig != w_b_dig);
  assign w_dig_lt = (w_a_dig < w_b_dig);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt     <= '0;
      r_decided <= 1'b0;
      r_acc_lt  <= 1'b0;
      r_acc_idx <= '0;
      r_out_lt  <= 1'b0;
      r_out_eq  <= 1'b0;
      r_out_gt  <= 1'b0;
      r_out_idx <= '0;
    end else begin
      if (w_accept) begin
        if (!r_decided && w_diff) begin
          r_decided <= 1'b1;
          r_acc_lt  <= w_dig_lt;
          r_acc_idx <= IDX_W'(r_cnt);
        end
        if (w_last) begin
          r_cnt     <= '0;
          r_out_lt  <= r_decided ? r_acc_lt  : (w_diff & w_dig_lt);
          r_out_gt  <= r_decided ? ~r_acc_lt : (w_diff & ~w_dig_lt);
          r_out_eq  <= ~r_decided & ~w_diff;
          r_out_idx <= r_decided ? r_acc_idx : (w_diff ? IDX_W'(r_cnt) : IDX_W'(N));
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
      if (w_release) r_decided <= 1'b0;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_out_valid;
  assign bus.out_lt    = r_out_lt;
  assign bus.out_eq    = r_out_eq;
  assign bus.out_gt    = r_out_gt;
  assign bus.out_idx   = r_out_idx;
endmodule

// File: tb/tb_comparator_signed_serial_rx.sv
// Directed bench: a signed and an unsigned instance receive identical digit streams; each verdict
// is compared against hand-computed lt/eq/gt and decision-index values.
module tb_comparator_signed_serial_rx;
  localparam int WIDTH = 32;
  localparam int DIGIT = 4;
  localparam int N     = WIDTH / DIGIT;
  localparam int IDX_W = $clog2(N) + 1;

  localparam logic [2:0] LT = 3'b100;
  localparam logic [2:0] EQ = 3'b010;
  localparam logic [2:0] GT = 3'b001;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  comparator_signed_serial_rx_if #(.DIGIT(DIGIT), .IDX_W(IDX_W)) if_s ();
  comparator_signed_serial_rx_if #(.DIGIT(DIGIT), .IDX_W(IDX_W)) if_u ();

  comparator_signed_serial_rx #(.WIDTH(WIDTH), .DIGIT(DIGIT), .SIGNED(1'b1)) dut_s (
    .clk (clk),
    .rst (rst),
    .bus (if_s.slave)
  );

  comparator_signed_serial_rx #(.WIDTH(WIDTH), .DIGIT(DIGIT), .SIGNED(1'b0)) dut_u (
    .clk (clk),
    .rst (rst),
    .bus (if_u.slave)
  );

  typedef struct {
    logic [31:0]      a;
    logic [31:0]      b;
    logic [2:0]       s_v;
    logic [IDX_W-1:0] s_idx;
    logic [2:0]       u_v;
    logic [IDX_W-1:0] u_idx;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic v, input logic [DIGIT-1:0] a, input logic [DIGIT-1:0] b);
    if_s.in_valid = v; if_s.in_a = a; if_s.in_b = b;
    if_u.in_valid = v; if_u.in_a = a; if_u.in_b = b;
  endtask

  task automatic set_out_ready(input logic r);
    if_s.out_ready = r;
    if_u.out_ready = r;
  endtask

  // Streams one pair MSB-first; returns #1 after the edge that accepted the last digit.
  task automatic stream(input logic [31:0] a, input logic [31:0] b, input int bubble_after);
    int guard;
    for (int k = 0; k < N; k++) begin
      drive(1'b1, a[WIDTH-1-DIGIT*k -: DIGIT], b[WIDTH-1-DIGIT*k -: DIGIT]);
      guard = 0;
      while (!if_s.in_ready && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      check("in_ready_before_beat", 32'(if_s.in_ready), 32'd1);
      if (k == N - 1) check("out_valid_before_last", 32'(if_s.out_valid), 32'd0);
      @(posedge clk); #1;
      if (k == bubble_after) begin
        drive(1'b0, DIGIT'($urandom), DIGIT'($urandom));
        repeat (2) @(posedge clk);
        #1;
        check("out_valid_during_bubble", 32'(if_s.out_valid), 32'd0);
      end
    end
  endtask

  task automatic check_result(input string tag, input logic [2:0] s_v, input logic [IDX_W-1:0] s_idx,
                              input logic [2:0] u_v, input logic [IDX_W-1:0] u_idx);
    check({tag, "_s_valid"}, 32'(if_s.out_valid), 32'd1);
    check({tag, "_s_ready"}, 32'(if_s.in_ready), 32'd0);
    check({tag, "_s_verdict"}, 32'({if_s.out_lt, if_s.out_eq, if_s.out_gt}), 32'(s_v));
    check({tag, "_s_idx"}, 32'(if_s.out_idx), 32'(s_idx));
    check({tag, "_u_verdict"}, 32'({if_u.out_lt, if_u.out_eq, if_u.out_gt}), 32'(u_v));
    check({tag, "_u_idx"}, 32'(if_u.out_idx), 32'(u_idx));
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_valid"}, 32'(if_s.out_valid), 32'd0);
    check({tag, "_ready"}, 32'(if_s.in_ready), 32'd1);
    check({tag, "_flags"}, 32'({if_s.out_lt, if_s.out_eq, if_s.out_gt}), 32'd0);
    check({tag, "_idx"}, 32'(if_s.out_idx), 32'd0);
  endtask

  initial begin
    vecs[0] = '{32'hFFFF_FFFF, 32'h0000_0000, LT, 4'd0, GT, 4'd0};
    vecs[1] = '{32'h0000_0005, 32'h0000_0005, EQ, 4'd8, EQ, 4'd8};
    vecs[2] = '{32'h7FFF_FFFF, 32'h8000_0000, GT, 4'd0, LT, 4'd0};
    vecs[3] = '{32'h1234_5678, 32'h1234_5679, LT, 4'd7, LT, 4'd7};
    vecs[4] = '{32'h9234_5678, 32'h1234_5678, LT, 4'd0, GT, 4'd0};
    vecs[5] = '{32'h0000_0003, 32'h0000_0002, GT, 4'd7, GT, 4'd7};
    vecs[6] = '{32'h8000_0000, 32'h8000_0001, LT, 4'd7, LT, 4'd7};
    vecs[7] = '{32'hFFFF_FFFF, 32'hFFFF_FFFE, GT, 4'd7, GT, 4'd7};
    vecs[8] = '{32'h0000_0010, 32'h0000_0100, LT, 4'd5, LT, 4'd5};

    rst = 1'b1;
    drive(1'b0, '0, '0);
    set_out_ready(1'b1);
    repeat (2) @(posedge clk);
    #1;
    check_reset_state("reset");
    rst = 1'b0;

    // Back-to-back pairs with out_ready held high.
    for (int i = 0; i < 9; i++) begin
      stream(vecs[i].a, vecs[i].b, -1);
      check_result($sformatf("vec%0d", i), vecs[i].s_v, vecs[i].s_idx, vecs[i].u_v, vecs[i].u_idx);
    end
    drive(1'b0, '0, '0);
    @(posedge clk); #1;
    check("drain_valid", 32'(if_s.out_valid), 32'd0);

    // Backpressure: verdict must hold while in_valid stays high with garbage digits.
    set_out_ready(1'b0);
    stream(32'hFFFF_FFFF, 32'h0000_0000, -1);
    for (int c = 0; c < 3; c++) begin
      drive(1'b1, DIGIT'($urandom), DIGIT'($urandom));
      check_result($sformatf("stall%0d", c), LT, 4'd0, GT, 4'd0);
      @(posedge clk); #1;
    end
    check_result("stall_end", LT, 4'd0, GT, 4'd0);
    set_out_ready(1'b1);
    @(posedge clk); #1;
    check("release_ready", 32'(if_s.in_ready), 32'd1);
    check("release_valid", 32'(if_s.out_valid), 32'd0);
    stream(32'h0000_0003, 32'h0000_0002, -1);
    check_result("after_stall", GT, 4'd7, GT, 4'd7);
    drive(1'b0, '0, '0);
    @(posedge clk); #1;

    // Reset mid-operand, then an equal pair with a two-cycle bubble after beat 4.
    drive(1'b1, 4'hF, 4'h0);
    @(posedge clk); #1;
    drive(1'b1, 4'h0, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    drive(1'b1, 4'h7, 4'h1);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b0, '0, '0);
    check_reset_state("midreset");
    stream(32'h0000_0000, 32'h0000_0000, 3);
    check_result("post_reset_eq", EQ, 4'd8, EQ, 4'd8);
    drive(1'b0, '0, '0);
    @(posedge clk); #1;
    check("final_valid", 32'(if_s.out_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
